// File: rtl/dbus_master_arbiter_pkg.sv
// Shared constants and types for the data-bus master arbiter: FSM encodings,
// master indices, and the latched request record.
package dbus_master_arbiter_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_ACK    = 2'd2;

    localparam logic [1:0] MODE_NONE = 2'b00;

    localparam int MST_CPU = 0;
    localparam int MST_DBG = 1;
    localparam int MST_DMA = 2;

    // Access counter width; holds ACC_CYCLES-1 for ACC_CYCLES up to 15.
    localparam int CNT_W = 4;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] write_data;
        logic [1:0]  reqw;
        logic [1:0]  mode;
        logic        reqs;
    } bus_req_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dbus_master_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index scanning upward from
// the pointer, wrapping from NM-1 back to 0.
module rr_pick
    import dbus_master_arbiter_pkg::*;
#(
    parameter  int NM = 3,
    localparam int IW = idx_width(NM)
) (
    input  logic [NM-1:0] eligible,
    input  logic [IW-1:0] ptr,
    output logic [NM-1:0] winner_oh,
    output logic [IW-1:0] winner_idx,
    output logic          valid
);

    logic [IW:0] cand;

    // NOTE: every output gets a default before the scan so no path leaves a
    // value unassigned, which is what keeps this block free of latches.
    always_comb begin
        winner_oh  = '0;
        winner_idx = '0;
        valid      = 1'b0;
        cand       = '0;
        for (int k = 0; k < NM; k++) begin
            cand = {1'b0, ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(NM)) begin
                cand = cand - (IW+1)'(NM);
            end
            if (!valid && eligible[cand[IW-1:0]]) begin
                valid      = 1'b1;
                winner_idx = cand[IW-1:0];
            end
        end
        if (valid) begin
            winner_oh[winner_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/dbus_master_arbiter.sv
// Round-robin arbiter sharing one data bus between NM masters, one fixed-length
// transaction at a time: IDLE -> ACCESS (ACC_CYCLES) -> ACK -> IDLE.
module dbus_master_arbiter
    import dbus_master_arbiter_pkg::*;
#(
    parameter int NM          = 3,
    parameter int ACC_CYCLES  = 1,
    parameter int HALT_MASTER = MST_DBG
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ds_cpu_halt,
    input  logic [NM-1:0]     m_req,
    input  logic [32*NM-1:0]  m_address,
    input  logic [32*NM-1:0]  m_write_data,
    input  logic [2*NM-1:0]   m_reqw,
    input  logic [2*NM-1:0]   m_mode,
    input  logic [NM-1:0]     m_reqs,
    output logic [NM-1:0]     m_gnt,
    output logic [NM-1:0]     m_ack,
    output logic [31:0]       m_read_data,
    output logic [31:0]       slv_address,
    output logic [31:0]       slv_write_data,
    output logic [1:0]        slv_reqw,
    output logic [1:0]        slv_mode,
    output logic              slv_reqs,
    input  logic [31:0]       slv_read_data
);

    localparam int IW = idx_width(NM);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    owner_idx;
    bus_req_t         lat;
    bus_req_t         cand;

    logic [NM-1:0]    halt_mask;
    logic [NM-1:0]    eligible;
    logic [NM-1:0]    pick_oh;
    logic [IW-1:0]    pick_idx;
    logic             pick_valid;
    logic             bus_active;

    // While halted only the debug master may win; m_ack masks a held request
    // from being re-granted in the acknowledge cycle.
    always_comb begin
        halt_mask = ds_cpu_halt ? (NM'(1) << HALT_MASTER) : {NM{1'b1}};
        eligible  = m_req & ~m_ack & halt_mask;
    end

    rr_pick #(
        .NM(NM)
    ) u_pick (
        .eligible   (eligible),
        .ptr        (rr_ptr),
        .winner_oh  (pick_oh),
        .winner_idx (pick_idx),
        .valid      (pick_valid)
    );

    always_comb begin
        cand.address    = m_address[32*pick_idx +: 32];
        cand.write_data = m_write_data[32*pick_idx +: 32];
        cand.reqw       = m_reqw[2*pick_idx +: 2];
        cand.mode       = m_mode[2*pick_idx +: 2];
        cand.reqs       = m_reqs[pick_idx];
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            rr_ptr      <= '0;
            owner_idx   <= '0;
            lat         <= '0;
            m_gnt       <= '0;
            m_ack       <= '0;
            m_read_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        owner_idx <= pick_idx;
                        lat       <= cand;
                        m_gnt     <= pick_oh;
                        cnt       <= CNT_W'(ACC_CYCLES - 1);
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (cnt == '0) begin
                        m_read_data <= slv_read_data;
                        m_ack       <= m_gnt;
                        m_gnt       <= '0;
                        state       <= ST_ACK;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_ACK: begin
                    m_ack  <= '0;
                    rr_ptr <= (owner_idx == IW'(NM - 1)) ? '0 : owner_idx + 1'b1;
                    state  <= ST_IDLE;
                end
                default: begin
                    m_gnt <= '0;
                    m_ack <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // The slave bus only carries the latched request during ACCESS; a mode of
    // MODE_NONE everywhere else leaves the bus untouched.
    assign bus_active = (state == ST_ACCESS);

    always_comb begin
        slv_address    = bus_active ? lat.address    : '0;
        slv_write_data = bus_active ? lat.write_data : '0;
        slv_reqw       = bus_active ? lat.reqw       : '0;
        slv_mode       = bus_active ? lat.mode       : MODE_NONE;
        slv_reqs       = bus_active ? lat.reqs       : 1'b0;
    end

endmodule

// File: tb/tb_dbus_master_arbiter.sv
// Bench for dbus_master_arbiter: two instances (1-cycle and 3-cycle access)
// checked every cycle against a transaction-timeline model, plus directed cases.
module tb_dbus_master_arbiter;

    localparam int ACC0 = 1;
    localparam int ACC1 = 3;

    logic clk;
    logic reset;

    logic        halt  [2];
    logic [2:0]  req   [2];
    logic [95:0] addr  [2];
    logic [95:0] wd    [2];
    logic [5:0]  reqw  [2];
    logic [5:0]  mode  [2];
    logic [2:0]  reqs  [2];
    logic [31:0] srd   [2];

    logic [2:0]  gnt    [2];
    logic [2:0]  ack    [2];
    logic [31:0] rd     [2];
    logic [31:0] s_addr [2];
    logic [31:0] s_wd   [2];
    logic [1:0]  s_reqw [2];
    logic [1:0]  s_mode [2];
    logic        s_reqs [2];

    int total = 0;
    int bad   = 0;

    // Reference model: a transaction starts at its IDLE decision cycle t0;
    // grant spans t0+1..t0+ACC, ack at t0+ACC+1, next decision at t0+ACC+2.
    int          cyc;
    bit          active   [2];
    int          t0       [2];
    int          owner    [2];
    int          ptr      [2];
    logic [31:0] l_addr   [2];
    logic [31:0] l_wd     [2];
    logic [1:0]  l_reqw   [2];
    logic [1:0]  l_mode   [2];
    logic        l_reqs   [2];
    logic [31:0] exp_rd   [2];
    logic [2:0]  prev_gnt [2];
    logic [2:0]  seen_ack [2];
    int          glog0[$];
    int          glog1[$];

    dbus_master_arbiter #(.NM(3), .ACC_CYCLES(ACC0), .HALT_MASTER(1)) u_dut0 (
        .clk            (clk),
        .reset          (reset),
        .ds_cpu_halt    (halt[0]),
        .m_req          (req[0]),
        .m_address      (addr[0]),
        .m_write_data   (wd[0]),
        .m_reqw         (reqw[0]),
        .m_mode         (mode[0]),
        .m_reqs         (reqs[0]),
        .m_gnt          (gnt[0]),
        .m_ack          (ack[0]),
        .m_read_data    (rd[0]),
        .slv_address    (s_addr[0]),
        .slv_write_data (s_wd[0]),
        .slv_reqw       (s_reqw[0]),
        .slv_mode       (s_mode[0]),
        .slv_reqs       (s_reqs[0]),
        .slv_read_data  (srd[0])
    );

    dbus_master_arbiter #(.NM(3), .ACC_CYCLES(ACC1), .HALT_MASTER(1)) u_dut1 (
        .clk            (clk),
        .reset          (reset),
        .ds_cpu_halt    (halt[1]),
        .m_req          (req[1]),
        .m_address      (addr[1]),
        .m_write_data   (wd[1]),
        .m_reqw         (reqw[1]),
        .m_mode         (mode[1]),
        .m_reqs         (reqs[1]),
        .m_gnt          (gnt[1]),
        .m_ack          (ack[1]),
        .m_read_data    (rd[1]),
        .slv_address    (s_addr[1]),
        .slv_write_data (s_wd[1]),
        .slv_reqw       (s_reqw[1]),
        .slv_mode       (s_mode[1]),
        .slv_reqs       (s_reqs[1]),
        .slv_read_data  (srd[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=no finish required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            active[d]   = 1'b0;
            t0[d]       = 0;
            owner[d]    = 0;
            ptr[d]      = 0;
            exp_rd[d]   = '0;
            prev_gnt[d] = '0;
            seen_ack[d] = '0;
        end
    endtask

    // Evaluate the current cycle for both instances, then advance one clock.
    task automatic tick();
        for (int d = 0; d < 2; d++) begin
            int         acc;
            int         p;
            logic [2:0] e_gnt;
            logic [2:0] e_ack;
            logic [2:0] elig;
            logic [1:0] e_mode;
            acc    = (d == 0) ? ACC0 : ACC1;
            p      = active[d] ? cyc - t0[d] : -1;
            e_gnt  = '0;
            e_ack  = '0;
            e_mode = 2'b00;
            if (active[d] && p >= 1 && p <= acc) begin
                e_gnt  = 3'(1 << owner[d]);
                e_mode = l_mode[d];
            end else if (active[d] && p == acc + 1) begin
                e_ack = 3'(1 << owner[d]);
            end else begin
                active[d] = 1'b0;
                elig = req[d] & (halt[d] ? 3'b010 : 3'b111);
                for (int k = 0; k < 3; k++) begin
                    int idx;
                    idx = (ptr[d] + k) % 3;
                    if (!active[d] && elig[idx]) begin
                        active[d] = 1'b1;
                        t0[d]     = cyc;
                        owner[d]  = idx;
                        l_addr[d] = addr[d][32*idx +: 32];
                        l_wd[d]   = wd[d][32*idx +: 32];
                        l_reqw[d] = reqw[d][2*idx +: 2];
                        l_mode[d] = mode[d][2*idx +: 2];
                        l_reqs[d] = reqs[d][idx];
                    end
                end
            end

            check($sformatf("d%0d c%0d m_gnt", d, cyc), gnt[d], e_gnt);
            check($sformatf("d%0d c%0d m_ack", d, cyc), ack[d], e_ack);
            check($sformatf("d%0d c%0d m_read_data", d, cyc), rd[d], exp_rd[d]);
            check($sformatf("d%0d c%0d slv_mode", d, cyc), s_mode[d], e_mode);
            if (e_gnt != '0) begin
                check($sformatf("d%0d c%0d slv_bus", d, cyc),
                      {s_addr[d], s_wd[d], s_reqw[d], s_reqs[d]},
                      {l_addr[d], l_wd[d], l_reqw[d], l_reqs[d]});
            end

            if (gnt[d] != '0 && prev_gnt[d] == '0) begin
                for (int i = 0; i < 3; i++) begin
                    if (gnt[d][i]) begin
                        if (d == 0) glog0.push_back(i);
                        else        glog1.push_back(i);
                    end
                end
            end
            prev_gnt[d] = gnt[d];
            seen_ack[d] = ack[d];

            if (active[d] && p == acc) exp_rd[d] = srd[d];
            if (e_ack != '0) ptr[d] = (owner[d] + 1) % 3;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic rand_inputs();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 3; i++) begin
                if (req[d][i] && seen_ack[d][i]) begin
                    req[d][i] = 1'b0;
                end else if (!req[d][i] && $urandom_range(3) == 0) begin
                    req[d][i]           = 1'b1;
                    addr[d][32*i +: 32] = $urandom;
                    wd[d][32*i +: 32]   = $urandom;
                    reqw[d][2*i +: 2]   = 2'($urandom_range(3));
                    mode[d][2*i +: 2]   = 2'($urandom_range(3));
                    reqs[d][i]          = 1'($urandom_range(1));
                end else if (req[d][i] && $urandom_range(63) == 0) begin
                    req[d][i] = 1'b0;
                end
                if ($urandom_range(15) == 0) addr[d][32*i +: 32] = $urandom;
            end
            if ($urandom_range(31) == 0) halt[d] = ~halt[d];
            srd[d] = $urandom;
        end
    endtask

    initial begin
        reset = 1'b1;
        cyc   = 0;
        for (int d = 0; d < 2; d++) begin
            halt[d] = 1'b0;
            req[d]  = '0;
            addr[d] = '0;
            wd[d]   = '0;
            reqw[d] = '0;
            mode[d] = '0;
            reqs[d] = '0;
            srd[d]  = '0;
        end
        model_reset();
        repeat (2) @(negedge clk);

        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset state d%0d", d),
                  {gnt[d], ack[d], rd[d], s_addr[d], s_wd[d], s_reqw[d], s_mode[d], s_reqs[d]},
                  128'd0);
        end
        reset = 1'b0;

        // All three requesting continuously from pointer 0.
        req[0]  = 3'b111;
        mode[0] = 6'b01_01_01;
        addr[0] = {32'h0000_2000, 32'h0000_1000, 32'h0000_0100};
        wd[0]   = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
        srd[0]  = 32'h5A5A_0001;
        repeat (18) tick();
        for (int i = 0; i < 6; i++) begin
            check($sformatf("rr order #%0d", i), (i < glog0.size()) ? glog0[i] : -1, i % 3);
        end
        req[0] = '0;
        repeat (3) tick();

        // Halt: only debug granted, then rotation resumes past debug.
        glog0.delete();
        halt[0] = 1'b1;
        req[0]  = 3'b111;
        repeat (9) tick();
        halt[0] = 1'b0;
        repeat (6) tick();
        for (int i = 0; i < 5; i++) begin
            int want;
            want = (i < 3) ? 1 : ((i == 3) ? 2 : 0);
            check($sformatf("halt order #%0d", i), (i < glog0.size()) ? glog0[i] : -1, want);
        end
        req[0] = '0;
        repeat (3) tick();

        // Single CPU read with one-cycle access.
        req[0]         = 3'b001;
        addr[0][31:0]  = 32'h0000_3004;
        mode[0][1:0]   = 2'b01;
        srd[0]         = 32'hDEAD_BEEF;
        tick();
        check("cpu read slv_address", s_addr[0], 32'h0000_3004);
        check("cpu read m_gnt", gnt[0], 3'b001);
        tick();
        check("cpu read m_ack", ack[0], 3'b001);
        check("cpu read m_read_data", rd[0], 32'hDEAD_BEEF);
        req[0] = '0;
        tick();
        check("cpu read ack single pulse", ack[0], 3'b000);
        check("cpu read data held", rd[0], 32'hDEAD_BEEF);

        // DMA write with three-cycle access; address changes mid-access are ignored.
        req[1]          = 3'b100;
        addr[1][95:64]  = 32'h0000_4034;
        wd[1][95:64]    = 32'h0000_1234;
        mode[1][5:4]    = 2'b10;
        reqw[1][5:4]    = 2'b10;
        srd[1]          = 32'h7777_0000;
        tick();
        for (int a = 0; a < 3; a++) begin
            check($sformatf("dma write addr cyc%0d", a), s_addr[1], 32'h0000_4034);
            check($sformatf("dma write data cyc%0d", a), s_wd[1], 32'h0000_1234);
            check($sformatf("dma write gnt cyc%0d", a), gnt[1], 3'b100);
            addr[1][95:64] = 32'hFFFF_0000 ^ 32'(a);
            tick();
        end
        check("dma write ack on 4th cycle", ack[1], 3'b100);
        req[1] = '0;
        repeat (3) tick();

        // Halt rises during a CPU access: CPU completes, then only debug wins.
        glog1.delete();
        req[1]          = 3'b101;
        addr[1][31:0]   = 32'h0000_0100;
        mode[1][1:0]    = 2'b01;
        mode[1][5:4]    = 2'b01;
        tick();
        tick();
        halt[1]         = 1'b1;
        req[1]          = 3'b111;
        addr[1][63:32]  = 32'h0000_0800;
        mode[1][3:2]    = 2'b01;
        repeat (12) tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("halt mid-access order #%0d", i),
                  (i < glog1.size()) ? glog1[i] : -1, (i == 0) ? 0 : 1);
        end
        halt[1] = 1'b0;
        req[1]  = '0;
        repeat (6) tick();

        // Asynchronous reset during ACCESS.
        glog1.delete();
        req[1]        = 3'b001;
        srd[1]        = 32'h1357_9BDF;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("async reset outputs d1",
              {gnt[1], ack[1], rd[1], s_addr[1], s_wd[1], s_reqw[1], s_mode[1], s_reqs[1]},
              128'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        req[1] = 3'b111;
        repeat (4) tick();
        check("pointer zero after reset", (glog1.size() > 0) ? glog1[0] : -1, 0);
        req[1] = '0;
        repeat (4) tick();

        // Randomized traffic on both instances.
        repeat (600) begin
            rand_inputs();
            tick();
        end
        for (int d = 0; d < 2; d++) begin
            req[d]  = '0;
            halt[d] = 1'b0;
        end
        repeat (10) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
